// File: rtl/ddr3_triple_buffer_read_scheduler_pkg.sv
// Shared types and constants for the DDR3 triple-buffer read scheduler.
//   state_t   : scheduler FSM states
//   buf_idx_t : index of one of the three frame buffers
//   addr_t    : 27-bit DDR3 word address
//   cmd_t     : start command {third_index[1:0], address[26:0]}
//   THIRD_*   : third index values carried in cmd_t[28:27]
package ddr3_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  typedef logic [1:0]  buf_idx_t;
  typedef logic [26:0] addr_t;
  typedef logic [28:0] cmd_t;

  localparam logic [1:0] THIRD_LEFT   = 2'd0;
  localparam logic [1:0] THIRD_CENTER = 2'd1;
  localparam logic [1:0] THIRD_RIGHT  = 2'd2;

endpackage

// File: rtl/ddr3_triple_buffer_read_scheduler_if.sv
// Start-command handshake between the read scheduler and the grayscale
// DDR3 reader.
//   start_data  : {third_index, word address}, scheduler -> reader
//   start_valid : command valid, scheduler -> reader
//   start_ready : one-cycle accept pulse, reader -> scheduler
// master = scheduler side, slave = reader side.
interface ddr3_triple_buffer_read_scheduler_if;
  import ddr3_sched_pkg::*;

  cmd_t start_data;
  logic start_valid;
  logic start_ready;

  modport master (output start_data, output start_valid, input start_ready);
  modport slave  (input start_data, input start_valid, output start_ready);

endinterface

// File: rtl/ddr3_triple_buffer_read_scheduler_triple_buffer_ctrl.sv
// Triple-buffer role bookkeeping. Tracks which buffer is being written (W),
// which holds the most recent completed frame (L) and which is protected
// for reading (R). The three roles always form a permutation of {0,1,2}.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_done    : writer finished buffer W
//   rd_start   : a frame read is starting now
//   w_idx/r_idx   : registered write / read buffer indices
//   w_next/r_next : indices that take effect on the next edge
//   ever       : at least one frame has been completed
module triple_buffer_ctrl
  import ddr3_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     wr_done,
  input  logic     rd_start,
  output buf_idx_t w_idx,
  output buf_idx_t r_idx,
  output buf_idx_t w_next,
  output buf_idx_t r_next,
  output logic     ever
);

  buf_idx_t w_q, l_q, r_q;
  buf_idx_t w_n, l_n, r_n;
  logic     fresh_q, fresh_n;
  logic     ever_q, ever_n;

  always_comb begin
    w_n     = w_q;
    l_n     = l_q;
    r_n     = r_q;
    fresh_n = fresh_q;
    ever_n  = ever_q;
    if (wr_done && rd_start) begin
      // The just-finished buffer goes straight to the reader; the old
      // read buffer becomes "latest" (already consumed) and the writer
      // takes the old latest.
      r_n     = w_q;
      l_n     = r_q;
      w_n     = l_q;
      fresh_n = 1'b0;
      ever_n  = 1'b1;
    end else if (wr_done) begin
      w_n     = l_q;
      l_n     = w_q;
      fresh_n = 1'b1;
      ever_n  = 1'b1;
    end else if (rd_start && fresh_q) begin
      // Without a fresh frame R is kept, so the previous frame repeats.
      r_n     = l_q;
      l_n     = r_q;
      fresh_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q     <= 2'd0;
      l_q     <= 2'd1;
      r_q     <= 2'd2;
      fresh_q <= 1'b0;
      ever_q  <= 1'b0;
    end else begin
      w_q     <= w_n;
      l_q     <= l_n;
      r_q     <= r_n;
      fresh_q <= fresh_n;
      ever_q  <= ever_n;
    end
  end

  assign w_idx  = w_q;
  assign r_idx  = r_q;
  assign w_next = w_n;
  assign r_next = r_n;
  assign ever   = ever_q;

endmodule

// File: rtl/ddr3_triple_buffer_read_scheduler.sv
// Whole-frame read scheduler for the DDR3 frame store. Issues the three
// per-third start commands (left, center, right) to the reader, one at a
// time, and arbitrates the three frame buffers with the camera writer.
//   ddr3clk, ddr3clk_reset_n : clock, asynchronous active-low reset
//   frame_req     : downstream frame request pulse
//   wr_frame_done : writer finished buffer wr_buf_index
//   wr_buf_index, wr_buf_base : buffer the writer fills next and its base
//   rd_third_done : reader returned the last beat of the current third
//   rd_cmd        : start_data/start_valid/start_ready to the reader
//   rd_buf_index  : buffer protected for reading
//   busy          : frame read in progress
//   overrun_count : saturating count of dropped frame requests
module ddr3_triple_buffer_read_scheduler
  import ddr3_sched_pkg::*;
#(
  parameter addr_t buf_base0     = 27'd0,
  parameter addr_t buf_stride    = 27'd32768,
  parameter addr_t third0_offset = 27'd0,
  parameter addr_t center_offset = 27'd15,
  parameter addr_t third2_offset = 27'd33
) (
  input  logic     ddr3clk,
  input  logic     ddr3clk_reset_n,
  input  logic     frame_req,
  input  logic     wr_frame_done,
  output buf_idx_t wr_buf_index,
  output addr_t    wr_buf_base,
  input  logic     rd_third_done,
  ddr3_triple_buffer_read_scheduler_if.master rd_cmd,
  output buf_idx_t rd_buf_index,
  output logic     busy,
  output logic [7:0] overrun_count
);

  // Address sums wrap modulo 2^27 by construction of addr_t.
  function automatic addr_t buf_addr(input buf_idx_t idx);
    case (idx)
      2'd0:    return buf_base0;
      2'd1:    return buf_base0 + buf_stride;
      default: return buf_base0 + {buf_stride[25:0], 1'b0};
    endcase
  endfunction

  function automatic addr_t offset_of(input logic [1:0] third_idx);
    case (third_idx)
      THIRD_LEFT:   return third0_offset;
      THIRD_CENTER: return center_offset;
      default:      return third2_offset;
    endcase
  endfunction

  state_t     state;
  logic [1:0] third;
  logic [1:0] third_nx;
  logic       pending;
  logic       rd_start;
  logic       start_valid_q;
  cmd_t       start_data_q;
  addr_t      wr_buf_base_q;
  buf_idx_t   w_idx, r_idx, w_next, r_next;
  logic       ever;

  triple_buffer_ctrl u_ctrl (
    .clk      (ddr3clk),
    .rst_n    (ddr3clk_reset_n),
    .wr_done  (wr_frame_done),
    .rd_start (rd_start),
    .w_idx    (w_idx),
    .r_idx    (r_idx),
    .w_next   (w_next),
    .r_next   (r_next),
    .ever     (ever)
  );

  // A read can start only once a frame exists, counting one that
  // completes in this very cycle.
  assign rd_start = (state == ST_IDLE) && (frame_req || pending) &&
                    (ever || wr_frame_done);
  assign third_nx = third + 2'd1;

  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n) begin
      state         <= ST_IDLE;
      third         <= THIRD_LEFT;
      pending       <= 1'b0;
      start_valid_q <= 1'b0;
      start_data_q  <= '0;
      busy          <= 1'b0;
      overrun_count <= 8'd0;
    end else begin
      // One-deep request queue while a frame is in flight.
      if (state != ST_IDLE && frame_req) begin
        if (pending) begin
          if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
        end else begin
          pending <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (frame_req || pending) begin
            pending <= 1'b0;
            if (rd_start) begin
              third         <= THIRD_LEFT;
              state         <= ST_ISSUE;
              busy          <= 1'b1;
              start_valid_q <= 1'b1;
              start_data_q  <= {THIRD_LEFT, buf_addr(r_next) + offset_of(THIRD_LEFT)};
            end
          end
        end
        ST_ISSUE: begin
          if (rd_cmd.start_ready) begin
            start_valid_q <= 1'b0;
            state         <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (rd_third_done) begin
            if (third == THIRD_RIGHT) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              third         <= third_nx;
              state         <= ST_ISSUE;
              start_valid_q <= 1'b1;
              start_data_q  <= {third_nx, buf_addr(r_idx) + offset_of(third_nx)};
            end
          end
        end
        default: begin
          state         <= ST_IDLE;
          busy          <= 1'b0;
          start_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Base tracks the write index that takes effect on the same edge.
  always_ff @(posedge ddr3clk or negedge ddr3clk_reset_n) begin
    if (!ddr3clk_reset_n) begin
      wr_buf_base_q <= buf_base0;
    end else begin
      wr_buf_base_q <= buf_addr(w_next);
    end
  end

  assign rd_cmd.start_valid = start_valid_q;
  assign rd_cmd.start_data  = start_data_q;
  assign wr_buf_index       = w_idx;
  assign wr_buf_base        = wr_buf_base_q;
  assign rd_buf_index       = r_idx;

endmodule

// File: tb/tb_ddr3_triple_buffer_read_scheduler.sv
module tb_ddr3_triple_buffer_read_scheduler;

  localparam logic [26:0] BASE0  = 27'd0;
  localparam logic [26:0] STRIDE = 27'd32768;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_req = 1'b0;
  logic        wr_frame_done = 1'b0;
  logic        rd_third_done = 1'b0;
  logic        ready_drv = 1'b0;
  logic [1:0]  wr_buf_index;
  logic [26:0] wr_buf_base;
  logic [1:0]  rd_buf_index;
  logic        busy;
  logic [7:0]  overrun_count;

  ddr3_triple_buffer_read_scheduler_if rd_cmd();
  assign rd_cmd.start_ready = ready_drv;

  ddr3_triple_buffer_read_scheduler #(
    .buf_base0     (27'd0),
    .buf_stride    (27'd32768),
    .third0_offset (27'd0),
    .center_offset (27'd15),
    .third2_offset (27'd33)
  ) dut (
    .ddr3clk         (clk),
    .ddr3clk_reset_n (rst_n),
    .frame_req       (frame_req),
    .wr_frame_done   (wr_frame_done),
    .wr_buf_index    (wr_buf_index),
    .wr_buf_base     (wr_buf_base),
    .rd_third_done   (rd_third_done),
    .rd_cmd          (rd_cmd),
    .rd_buf_index    (rd_buf_index),
    .busy            (busy),
    .overrun_count   (overrun_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (buffer roles as plain integers) ----
  logic [26:0] OFF [3] = '{27'd0, 27'd15, 27'd33};

  function automatic logic [28:0] cmd_of(input int r, input int t);
    logic [26:0] a;
    a = BASE0 + 27'(r) * STRIDE + OFF[t];
    return {2'(t), a};
  endfunction

  int   m_w = 0, m_l = 1, m_r = 2, m_tmp;
  bit   m_fresh = 0, m_ever = 0, m_pend = 0, m_active = 0;
  bit   m_await = 0, m_want = 0, m_st = 0, m_done_ok = 0;
  int   m_dones = 0, m_ovf = 0;
  logic [28:0] exp_q[$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_w = 0; m_l = 1; m_r = 2;
      m_fresh = 0; m_ever = 0; m_pend = 0; m_active = 0;
      m_await = 0; m_want = 0; m_dones = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      m_st = 0;
      if (ready_drv) begin
        m_await = 1;
        m_want  = 0;
      end
      m_done_ok = rd_third_done && m_await;
      if (m_done_ok) begin
        m_await = 0;
        m_dones++;
      end
      if (!m_active) begin
        if (frame_req || m_pend) begin
          m_pend = 0;
          if (m_ever || wr_frame_done) m_st = 1;
        end
      end else begin
        if (frame_req) begin
          if (m_pend) begin
            if (m_ovf < 255) m_ovf++;
          end else m_pend = 1;
        end
        if (m_done_ok) begin
          if (m_dones == 3) m_active = 0;
          else m_want = 1;
        end
      end
      if (wr_frame_done && m_st) begin
        m_tmp = m_r; m_r = m_w; m_w = m_l; m_l = m_tmp;
        m_fresh = 0; m_ever = 1;
      end else if (wr_frame_done) begin
        m_tmp = m_w; m_w = m_l; m_l = m_tmp;
        m_fresh = 1; m_ever = 1;
      end else if (m_st && m_fresh) begin
        m_tmp = m_r; m_r = m_l; m_l = m_tmp;
        m_fresh = 0;
      end
      if (m_st) begin
        m_active = 1;
        m_dones  = 0;
        m_want   = 1;
        for (int k = 0; k < 3; k++) exp_q.push_back(cmd_of(m_r, k));
      end
    end
  end

  // ---------------- reader responder ----------------
  int rdr_fixed = -1;
  int rs = 0, cnt = 0;
  bit armed = 0;

  function automatic int pick(input int hi);
    if (rdr_fixed >= 0) return rdr_fixed;
    return int'($urandom_range(0, hi));
  endfunction

  initial forever begin
    @(negedge clk);
    ready_drv     = 1'b0;
    rd_third_done = 1'b0;
    if (!rst_n) begin
      rs = 0;
      armed = 0;
    end else if (rs == 0) begin
      if (rd_cmd.start_valid) begin
        if (!armed) begin
          cnt = pick(3);
          armed = 1;
        end
        if (cnt <= 0) begin
          ready_drv = 1'b1;
          rs = 1;
          armed = 0;
          cnt = pick(4);
        end else begin
          cnt--;
          // A done pulse while a command is still unaccepted must be ignored.
          if ($urandom_range(0, 3) == 0) rd_third_done = 1'b1;
        end
      end
    end else begin
      if (cnt <= 0) begin
        rd_third_done = 1'b1;
        rs = 0;
      end else cnt--;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("start_valid", 32'(rd_cmd.start_valid), 32'(m_want));
      if (rd_cmd.start_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmd_unexpected actual=%0h required=none", rd_cmd.start_data);
        end else begin
          chk("start_data", 32'(rd_cmd.start_data), 32'(exp_q[0]));
          if (ready_drv) void'(exp_q.pop_front());
        end
      end
      chk("busy", 32'(busy), 32'(m_active));
      chk("rd_buf_index", 32'(rd_buf_index), 32'(m_r));
      chk("wr_buf_index", 32'(wr_buf_index), 32'(m_w));
      chk("wr_buf_base", 32'(wr_buf_base), 32'(BASE0 + 27'(m_w) * STRIDE));
      chk("overrun_count", 32'(overrun_count), 32'(m_ovf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit fr, input bit wd);
    @(negedge clk);
    frame_req = fr;
    wr_frame_done = wd;
    @(negedge clk);
    frame_req = 1'b0;
    wr_frame_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < 5000) begin
      @(negedge clk);
      n++;
      if (!m_active && !m_pend) quiet++;
      else quiet = 0;
    end
    total++;
    if (quiet < 4) begin
      bad++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_start_valid", 32'(rd_cmd.start_valid), 0);
    chk("rst_start_data", 32'(rd_cmd.start_data), 0);
    chk("rst_wr_idx", 32'(wr_buf_index), 0);
    chk("rst_rd_idx", 32'(rd_buf_index), 2);
    chk("rst_wr_base", 32'(wr_buf_base), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(overrun_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Request with no completed frame is discarded.
    pulse(1, 0);
    repeat (5) @(negedge clk);
    chk("no_frame_busy", 32'(busy), 0);
    chk("no_frame_ovf", 32'(overrun_count), 0);

    // Two frames written, then one read of buffer 1; then a repeat read.
    pulse(0, 1);
    pulse(0, 1);
    pulse(1, 0);
    wait_idle();
    chk("read1_rd_idx", 32'(rd_buf_index), 1);
    pulse(1, 0);
    wait_idle();
    chk("repeat_rd_idx", 32'(rd_buf_index), 1);

    // Simultaneous write-done and request straight out of reset.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse(1, 1);
    wait_idle();
    chk("same_cycle_rd_idx", 32'(rd_buf_index), 0);
    chk("same_cycle_wr_idx", 32'(wr_buf_index), 1);

    // Overrun counting and saturation during one long read.
    rdr_fixed = 120;
    pulse(0, 1);
    pulse(1, 0);
    repeat (3) pulse(1, 0);
    chk("ovf_two", 32'(overrun_count), 2);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      frame_req = 1'b1;
    end
    @(negedge clk);
    frame_req = 1'b0;
    chk("ovf_sat", 32'(overrun_count), 255);
    rdr_fixed = -1;
    wait_idle();

    // Stalled command stays put; reset in the middle of it clears it.
    rdr_fixed = 10;
    pulse(0, 1);
    pulse(1, 0);
    repeat (6) @(negedge clk);
    chk("stall_valid", 32'(rd_cmd.start_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rd_cmd.start_valid), 0);
    chk("midrst_data", 32'(rd_cmd.start_data), 0);
    chk("midrst_wr_idx", 32'(wr_buf_index), 0);
    chk("midrst_rd_idx", 32'(rd_buf_index), 2);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdr_fixed = -1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      frame_req     = ($urandom_range(0, 7) == 0);
      wr_frame_done = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    frame_req = 1'b0;
    wr_frame_done = 1'b0;
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
